// File: rtl/onehot_alu_pipe_if.sv
// Handshake/data bundle for onehot_alu_pipe: input beat channel,
// result channel and the saturating transfer counter.
interface onehot_alu_pipe_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             carry;
   logic             zero;
   logic             sel_err;
   logic [7:0]       op_count;

   // Producer/consumer side (drives beats, accepts results)
   modport master (
      output in_valid, sel, a, b, out_ready,
      input  in_ready, out_valid, y, carry, zero, sel_err, op_count
   );

   // ALU pipeline side
   modport slave (
      input  in_valid, sel, a, b, out_ready,
      output in_ready, out_valid, y, carry, zero, sel_err, op_count
   );
endinterface

// File: rtl/onehot_alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a one-hot operation select.
// S1 registers the raw beat, S2 registers the computed result; an S1 beat
// moves on whenever S2 is empty or being drained, so the pipe sustains one
// beat per cycle and accepts a new beat in the cycle a full pipe drains.
module onehot_alu_pipe #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   onehot_alu_pipe_if.slave  bus
);

   // True when exactly one select bit is set
   function automatic logic is_onehot(input logic [3:0] s);
      is_onehot = (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_sel_q,   s1_sel_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_y_q,     s2_y_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_zero_q,  s2_zero_d;
   logic             s2_err_q,   s2_err_d;
   logic [7:0]       op_count_q, op_count_d;

   logic             s1_adv_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] res_y_s;
   logic             res_carry_s;
   logic             res_err_s;

   // Handshake decisions; in_ready is held low during reset
   always_comb begin
      out_xfer_s = s2_valid_q && bus.out_ready;
      s1_adv_s   = s1_valid_q && (!s2_valid_q || bus.out_ready);
      if (rst) begin
         bus.in_ready = 1'b0;
      end else begin
         bus.in_ready = !s1_valid_q || s1_adv_s;
      end
      in_xfer_s = bus.in_valid && bus.in_ready;
   end

   // ALU on the S1 beat; invalid selects yield a zero result with sel_err
   always_comb begin
      sum_s       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      diff_s      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      res_y_s     = {WIDTH{1'b0}};
      res_carry_s = 1'b0;
      res_err_s   = !is_onehot(s1_sel_q);
      case (s1_sel_q)
         4'b0001: {res_carry_s, res_y_s} = sum_s;
         4'b0010: {res_carry_s, res_y_s} = diff_s;   // top bit is the borrow
         4'b0100: res_y_s = s1_a_q & s1_b_q;
         4'b1000: res_y_s = s1_a_q | s1_b_q;
         default: begin
            res_y_s     = {WIDTH{1'b0}};
            res_carry_s = 1'b0;
         end
      endcase
   end

   // Next-state for both stages and the saturating transfer counter
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sel_d   = s1_sel_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_y_d     = s2_y_q;
      s2_carry_d = s2_carry_q;
      s2_zero_d  = s2_zero_q;
      s2_err_d   = s2_err_q;
      op_count_d = op_count_q;

      if (in_xfer_s) begin
         s1_valid_d = 1'b1;
         s1_sel_d   = bus.sel;
         s1_a_d     = bus.a;
         s1_b_d     = bus.b;
      end else if (s1_adv_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      // S2 data only changes on a load, so it stays stable under backpressure
      if (s1_adv_s) begin
         s2_valid_d = 1'b1;
         s2_y_d     = res_y_s;
         s2_carry_d = res_carry_s;
         s2_zero_d  = (res_y_s == {WIDTH{1'b0}});
         s2_err_d   = res_err_s;
      end else if (out_xfer_s) begin
         s2_valid_d = 1'b0;
      end else begin
         s2_valid_d = s2_valid_q;
      end

      if (out_xfer_s && (op_count_q != 8'd255)) begin
         op_count_d = op_count_q + 8'd1;
      end else begin
         op_count_d = op_count_q;
      end
   end

   // State registers with synchronous reset discarding any in-flight beats
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sel_q   <= 4'b0000;
         s1_a_q     <= {WIDTH{1'b0}};
         s1_b_q     <= {WIDTH{1'b0}};
         s2_valid_q <= 1'b0;
         s2_y_q     <= {WIDTH{1'b0}};
         s2_carry_q <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_err_q   <= 1'b0;
         op_count_q <= 8'd0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sel_q   <= s1_sel_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_y_q     <= s2_y_d;
         s2_carry_q <= s2_carry_d;
         s2_zero_q  <= s2_zero_d;
         s2_err_q   <= s2_err_d;
         op_count_q <= op_count_d;
      end
   end

   // Result channel comes straight from the S2 registers
   always_comb begin
      bus.out_valid = s2_valid_q;
      bus.y         = s2_y_q;
      bus.carry     = s2_carry_q;
      bus.zero      = s2_zero_q;
      bus.sel_err   = s2_err_q;
      bus.op_count  = op_count_q;
   end

endmodule

// File: tb/tb_onehot_alu_pipe.sv
// Directed self-checking bench for onehot_alu_pipe (WIDTH = 4).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_onehot_alu_pipe;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   onehot_alu_pipe_if #(.WIDTH(4)) bus();
   onehot_alu_pipe #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Packed view of the result channel: {out_valid, y, carry, zero, sel_err}
   function automatic logic [7:0] res_now();
      res_now = {bus.out_valid, bus.y, bus.carry, bus.zero, bus.sel_err};
   endfunction

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.sel = 4'b0000;
      bus.a = 4'h0; bus.b = 4'h0; bus.out_ready = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %b want 0", bus.in_ready); end
      checks++; if (res_now() !== 8'h00) begin errors++; $display("FAIL reset_outputs got %h want 00", res_now()); end
      checks++; if (bus.op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", bus.op_count); end
      rst = 1'b0; #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got %b want 1", bus.in_ready); end
   endtask

   task automatic test_add();
      @(negedge clk);
      bus.sel = 4'b0001; bus.a = 4'b1001; bus.b = 4'b1000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got %b want 0", bus.out_valid); end
      @(negedge clk);
      checks++; if (res_now() !== {1'b1, 4'b0001, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL add_result got %b want %b", res_now(), {1'b1, 4'b0001, 3'b100}); end
      exp_cnt++;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.op_count !== exp_cnt[7:0]) begin errors++; $display("FAIL add_count got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid, bus.op_count, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] vs [4];
      logic [3:0] va [4];
      logic [3:0] vb [4];
      logic [7:0] ve [4];
      vs[0] = 4'b0010; va[0] = 4'b0011; vb[0] = 4'b0101; ve[0] = {1'b1, 4'b1110, 3'b100}; // SUB borrow
      vs[1] = 4'b0100; va[1] = 4'b1100; vb[1] = 4'b0011; ve[1] = {1'b1, 4'b0000, 3'b010}; // AND zero
      vs[2] = 4'b1000; va[2] = 4'b1010; vb[2] = 4'b0101; ve[2] = {1'b1, 4'b1111, 3'b000}; // OR
      vs[3] = 4'b0001; va[3] = 4'b1111; vb[3] = 4'b0001; ve[3] = {1'b1, 4'b0000, 3'b110}; // ADD wrap
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++; if (res_now() !== ve[i-2]) begin errors++; $display("FAIL b2b_beat%0d got %b want %b", i-2, res_now(), ve[i-2]); end
            exp_cnt++;
         end
         if (i < 4) begin
            bus.sel = vs[i]; bus.a = va[i]; bus.b = vb[i]; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.op_count !== exp_cnt[7:0]) begin errors++; $display("FAIL b2b_count got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid, bus.op_count, exp_cnt); end
   endtask

   task automatic test_sel_err();
      logic [3:0] vs [2];
      vs[0] = 4'b0110; vs[1] = 4'b0000;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++; if (res_now() !== {1'b1, 4'b0000, 3'b011}) begin errors++; $display("FAIL selerr_beat%0d got %b want %b", i-2, res_now(), {1'b1, 4'b0000, 3'b011}); end
            exp_cnt++;
         end
         if (i < 2) begin
            bus.sel = vs[i]; bus.a = 4'b1111; bus.b = 4'b1111; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (bus.op_count !== exp_cnt[7:0]) begin errors++; $display("FAIL selerr_count got %0d want %0d", bus.op_count, exp_cnt); end
   endtask

   task automatic test_backpressure();
      logic [7:0] e0, e1, e2;
      e0 = {1'b1, 4'b0111, 3'b000};
      e1 = {1'b1, 4'b1001, 3'b000};
      e2 = {1'b1, 4'b0110, 3'b000};
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.sel = 4'b0001; bus.a = 4'b0011; bus.b = 4'b0100; bus.in_valid = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2 got %b want 1", bus.in_ready); end
      bus.sel = 4'b1000; bus.a = 4'b1000; bus.b = 4'b0001;
      @(negedge clk);
      checks++; if (res_now() !== e0) begin errors++; $display("FAIL bp_first got %b want %b", res_now(), e0); end
      bus.sel = 4'b0100; bus.a = 4'b1111; bus.b = 4'b0110; #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall3 got %b want 0", bus.in_ready); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (res_now() !== e0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %b rdy=%b want %b rdy=0", k, res_now(), bus.in_ready, e0); end
      end
      bus.out_ready = 1'b1; #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_accept got %b want 1", bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (res_now() !== e1) begin errors++; $display("FAIL bp_second got %b want %b", res_now(), e1); end
      @(negedge clk);
      checks++; if (res_now() !== e2) begin errors++; $display("FAIL bp_third got %b want %b", res_now(), e2); end
      exp_cnt = exp_cnt + 3;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.op_count !== exp_cnt[7:0]) begin errors++; $display("FAIL bp_count got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid, bus.op_count, exp_cnt); end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.sel = 4'b0001; bus.a = 4'b0001; bus.b = 4'b0001; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.a = 4'b0010; bus.b = 4'b0010;
      @(negedge clk);
      bus.in_valid = 1'b0; rst = 1'b1; #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", bus.in_ready); end
      @(negedge clk);
      rst = 1'b0; exp_cnt = 0;
      checks++; if (res_now() !== 8'h00 || bus.op_count !== 8'd0) begin errors++; $display("FAIL mid_rst_clear got %b cnt=%0d want 00000000 cnt=0", res_now(), bus.op_count); end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_out%0d got %b want 0", k, bus.out_valid); end
      end
   endtask

   task automatic test_saturation();
      int         e;
      logic [3:0] ey;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 303; i++) begin
         @(negedge clk);
         e = (i < 2) ? 0 : i - 2;
         if (e > 255) e = 255;
         checks++; if (bus.op_count !== e[7:0]) begin errors++; $display("FAIL sat_count_%0d got %0d want %0d", i, bus.op_count, e); end
         checks++; if (bus.out_valid !== (i >= 2 && i < 302)) begin errors++; $display("FAIL sat_valid_%0d got %b", i, bus.out_valid); end
         if (i >= 2 && i < 302) begin
            e = i - 2; ey = e[3:0];
            checks++; if (bus.y !== ey) begin errors++; $display("FAIL sat_order_%0d got %h want %h", i, bus.y, ey); end
         end
         if (i < 300) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d got %b want 1", i, bus.in_ready); end
            e = i;
            bus.sel = 4'b0001; bus.a = e[3:0]; bus.b = 4'b0000; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_sel_err();
      test_backpressure();
      test_reset_midflight();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
